// File: rtl/int_sched_pkg.sv
// int_sched_pkg: register map, INTCFG field positions and reset values shared by int_sched
package int_sched_pkg;
    typedef enum logic [1:0] {
        A_LINE_LO = 2'd0,
        A_LINE_HI = 2'd1,
        A_HPOS    = 2'd2,
        A_CFG     = 2'd3
    } cfg_addr_e;

    localparam int         FRM_EN      = 0;
    localparam int         LIN_EN      = 1;
    localparam int         STEP_LSB    = 4;
    localparam logic [7:0] CFG_MASK    = 8'hF3;
    localparam logic [7:0] CFG_RST     = 8'h01;
    localparam logic [8:0] INTLINE_RST = 9'd0;
    localparam logic [7:0] HPOS_RST    = 8'd0;
endpackage

// File: rtl/int_sched_raster.sv
// int_sched_raster: saturating line/position counters and the line-interval phase counter
module int_sched_raster (
    input  logic       clk,
    input  logic       res,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       hcnt_tick,
    input  logic [3:0] step,
    output logic [8:0] vcnt,
    output logic [7:0] hcnt,
    output logic [3:0] phase
);
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vcnt  <= '0;
            hcnt  <= '0;
            phase <= '0;
        end else if (frame_start) begin
            vcnt  <= '0;
            hcnt  <= '0;
            phase <= '0;
        end else if (line_start) begin
            vcnt  <= vcnt + {8'd0, vcnt != 9'h1FF};
            hcnt  <= '0;
            phase <= phase == step ? 4'd0 : phase + 4'd1;
        end else if (hcnt_tick) begin
            hcnt  <= hcnt + {7'd0, hcnt != 8'hFF};
        end
    end
endmodule

// File: rtl/int_sched.sv
// int_sched: raster-position interrupt scheduler issuing frame and periodic line INT strobes
module int_sched
    import int_sched_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       hcnt_tick,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] cfg_rdata,
    output logic       int_start_frm,
    output logic       int_start_lin,
    output logic [8:0] line_num
);
    logic [7:0] shadow_lo, inthpos, intcfg, hcnt;
    logic [8:0] intline, vcnt;
    logic [3:0] phase;
    logic       frm_fired, lin_fired, boundary, match, frm_hit, lin_hit;

    int_sched_raster u_raster (
        .clk         (clk),
        .res         (res),
        .frame_start (frame_start),
        .line_start  (line_start),
        .hcnt_tick   (hcnt_tick),
        .step        (intcfg[STEP_LSB +: 4]),
        .vcnt        (vcnt),
        .hcnt        (hcnt),
        .phase       (phase)
    );

    assign line_num = vcnt;

    always_comb begin
        boundary  = line_start | frame_start;
        match     = hcnt_tick && !boundary && hcnt == inthpos;
        frm_hit   = match && intcfg[FRM_EN] && vcnt == intline && !frm_fired;
        lin_hit   = match && intcfg[LIN_EN] && phase == 4'd0 && !lin_fired;
        cfg_rdata = cfg_addr == A_LINE_LO ? intline[7:0] :
                    cfg_addr == A_LINE_HI ? {7'd0, intline[8]} :
                    cfg_addr == A_HPOS    ? inthpos : intcfg;
    end

    // the high-byte write commits the whole 9-bit line so intline never holds a torn value
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            shadow_lo <= '0;
            intline   <= INTLINE_RST;
            inthpos   <= HPOS_RST;
            intcfg    <= CFG_RST;
        end else if (cfg_we) begin
            if (cfg_addr == A_LINE_LO) shadow_lo <= cfg_wdata;
            if (cfg_addr == A_LINE_HI) intline <= {cfg_wdata[0], shadow_lo};
            if (cfg_addr == A_HPOS) inthpos <= cfg_wdata;
            if (cfg_addr == A_CFG) intcfg <= cfg_wdata & CFG_MASK;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            int_start_frm <= 1'b0;
            int_start_lin <= 1'b0;
            frm_fired     <= 1'b0;
            lin_fired     <= 1'b0;
        end else begin
            int_start_frm <= frm_hit;
            int_start_lin <= lin_hit;
            frm_fired     <= !boundary && (frm_fired || frm_hit);
            lin_fired     <= !boundary && (lin_fired || lin_hit);
        end
    end
endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: directed and random stimulus checked against an integer raster/interrupt model
module tb_int_sched;
    logic       clk = 1'b0;
    logic       res, frame_start, line_start, hcnt_tick, cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata, cfg_rdata;
    logic       int_start_frm, int_start_lin;
    logic [8:0] line_num;

    int errs = 0, checks = 0;
    int m_vc, m_hc, m_ph, m_il, m_sh, m_hp, m_cfg;
    bit m_ff, m_lf, e_frm, e_lin;
    int n_frm, n_lin, frm_line;
    int lin_q[$];

    int_sched dut (
        .clk           (clk),
        .res           (res),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .hcnt_tick     (hcnt_tick),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .int_start_frm (int_start_frm),
        .int_start_lin (int_start_lin),
        .line_num      (line_num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rd(input int a);
        case (a)
            0:       return m_il % 256;
            1:       return m_il / 256;
            2:       return m_hp;
            default: return m_cfg;
        endcase
    endfunction

    task automatic model_reset();
        m_vc = 0; m_hc = 0; m_ph = 0; m_il = 0; m_sh = 0; m_hp = 0; m_cfg = 1;
        m_ff = 0; m_lf = 0; e_frm = 0; e_lin = 0;
    endtask

    // one rising edge of the reference: compares use the state from before the edge
    task automatic model_clk(input bit fs, input bit ls, input bit tk, input bit we, input int a, input int d);
        bit hit, nf, nl;
        int stp;
        stp = m_cfg / 16;
        hit = tk && !ls && !fs && m_hc == m_hp;
        nf = hit && (m_cfg % 2 == 1) && m_vc == m_il && !m_ff;
        nl = hit && ((m_cfg / 2) % 2 == 1) && m_ph == 0 && !m_lf;
        e_frm = nf;
        e_lin = nl;
        if (fs || ls) begin
            m_ff = 0; m_lf = 0;
        end else begin
            if (nf) m_ff = 1;
            if (nl) m_lf = 1;
        end
        if (fs) begin
            m_vc = 0; m_hc = 0; m_ph = 0;
        end else if (ls) begin
            m_vc = (m_vc < 511) ? m_vc + 1 : 511;
            m_hc = 0;
            m_ph = (m_ph == stp) ? 0 : (m_ph + 1) % 16;
        end else if (tk) begin
            m_hc = (m_hc < 255) ? m_hc + 1 : 255;
        end
        if (we) begin
            if (a == 0) m_sh = d;
            if (a == 1) m_il = (d % 2) * 256 + m_sh;
            if (a == 2) m_hp = d;
            if (a == 3) m_cfg = d & 'hF3;
        end
    endtask

    task automatic step(input bit fs, input bit ls, input bit tk, input bit we, input int a, input int d);
        frame_start = fs; line_start = ls; hcnt_tick = tk; cfg_we = we;
        cfg_addr = 2'(a); cfg_wdata = 8'(d);
        #1;
        chk("frm", 32'(int_start_frm), 32'(e_frm));
        chk("lin", 32'(int_start_lin), 32'(e_lin));
        chk("line_num", 32'(line_num), m_vc);
        chk("rdata", 32'(cfg_rdata), rd(a));
        if (int_start_frm) begin n_frm++; frm_line = int'(line_num); end
        if (int_start_lin) begin n_lin++; lin_q.push_back(int'(line_num)); end
        @(posedge clk);
        model_clk(fs, ls, tk, we, a, d);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        step(0, 0, 0, 1, a, d);
    endtask

    task automatic line(input int ticks);
        step(0, 1, 0, 0, 3, 0);
        repeat (ticks) step(0, 0, 1, 0, 3, 0);
    endtask

    initial begin
        res = 1; frame_start = 0; line_start = 0; hcnt_tick = 0; cfg_we = 0;
        cfg_addr = 0; cfg_wdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        res = 0;

        n_frm = 0;
        step(0, 0, 0, 0, 3, 0);
        chk("rst_cfg", 32'(cfg_rdata), 32'h01);
        step(0, 0, 1, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);
        chk("frm_line0", n_frm, 1);

        wr(0, 'h2C);
        step(0, 0, 0, 0, 0, 0);
        chk("lo_shadow_only", 32'(cfg_rdata), 0);
        wr(1, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("intline_lo", 32'(cfg_rdata), 'h2C);
        wr(2, 2);
        step(1, 0, 0, 0, 3, 0);
        n_frm = 0; frm_line = -1;
        repeat (5) step(0, 0, 1, 0, 3, 0);
        for (int i = 0; i < 310; i++) line(5);
        chk("frm_cnt300", n_frm, 1);
        chk("frm_at300", frm_line, 300);

        wr(3, 'h22);
        lin_q.delete();
        step(1, 0, 0, 0, 3, 0);
        repeat (3) step(0, 0, 1, 0, 3, 0);
        for (int i = 0; i < 7; i++) line(3);
        step(1, 0, 0, 0, 3, 0);
        repeat (3) step(0, 0, 1, 0, 3, 0);
        for (int i = 0; i < 3; i++) line(3);
        step(0, 0, 0, 0, 3, 0);
        chk("lin_q_size", lin_q.size(), 5);
        if (lin_q.size() == 5) begin
            chk("lin_q0", lin_q[0], 0);
            chk("lin_q1", lin_q[1], 3);
            chk("lin_q2", lin_q[2], 6);
            chk("lin_q3", lin_q[3], 0);
            chk("lin_q4", lin_q[4], 3);
        end

        wr(2, 255);
        wr(3, 'h02);
        step(1, 0, 0, 0, 3, 0);
        n_lin = 0;
        repeat (300) step(0, 0, 1, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);
        chk("sat_lin_once", n_lin, 1);

        wr(2, 0);
        wr(3, 'h03);
        line(0);
        line(0);
        n_lin = 0; n_frm = 0;
        step(1, 1, 1, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);
        chk("fs_ls_vcnt", 32'(line_num), 0);
        step(0, 1, 1, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);
        chk("coinc_none", n_lin, 0);
        step(0, 0, 1, 0, 3, 0);
        step(0, 0, 0, 0, 3, 0);
        chk("after_coinc", n_lin, 1);

        wr(0, 3);
        wr(1, 0);
        wr(2, 1);
        wr(3, 1);
        step(1, 0, 0, 0, 3, 0);
        repeat (3) line(0);
        step(0, 0, 1, 0, 3, 0);
        hcnt_tick = 1; cfg_addr = 2'd3; cfg_we = 0;
        #2 res = 1;
        #1;
        chk("async_frm", 32'(int_start_frm), 0);
        chk("async_line", 32'(line_num), 0);
        chk("async_cfg", 32'(cfg_rdata), 32'h01);
        @(posedge clk);
        #1 chk("rst_no_strobe", 32'(int_start_frm), 0);
        @(negedge clk);
        res = 0; hcnt_tick = 0;
        model_reset();
        step(0, 0, 0, 0, 3, 0);

        for (int i = 0; i < 4000; i++) begin
            bit fs, ls, tk, we;
            int a, d;
            fs = $urandom_range(0, 499) == 0;
            ls = $urandom_range(0, 29) == 0;
            tk = $urandom_range(0, 9) < 7;
            we = $urandom_range(0, 24) == 0;
            a = $urandom_range(0, 3);
            d = a == 0 ? $urandom_range(0, 15) : a == 1 ? int'($urandom_range(0, 7) == 0) :
                a == 2 ? $urandom_range(0, 40) : int'($urandom_range(0, 255));
            step(fs, ls, tk, we, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have port res, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port frame_start, input, 1, one-cycle strobe at start of video frame.
REQ-004 SHALL have port line_start, input, 1, one-cycle strobe at start of each video line.
REQ-005 SHALL have port hcnt_tick, input, 1, horizontal position clock-enable.
REQ-006 SHALL have port cfg_we, input, 1, config register write strobe.
REQ-007 SHALL have port cfg_addr, input, 2, config register select.
REQ-008 SHALL have port cfg_wdata, input, 8, config write data.
REQ-009 SHALL have port cfg_rdata, output, 8, combinational readback of the selected register.
REQ-010 SHALL have port int_start_frm, output, 1, one-cycle frame INT request strobe to the INT controller.
REQ-011 SHALL have port int_start_lin, output, 1, one-cycle line INT request strobe to the INT controller.
REQ-012 SHALL have port line_num, output, 9, current raster line.

Function
REQ-013 SHALL define registers: addr0 INTLINE_LO (write to shadow only); addr1 INTLINE_HI (bit0); addr2 INTHPOS[7:0]; addr3 INTCFG {step[7:4], rsvd[3:2], lin_en[1], frm_en[0]}.
REQ-014 SHALL commit intline <= {cfg_wdata[0], shadow_lo} on an addr1 write, so a 9-bit line is updated atomically; an addr0 write alone SHALL NOT change intline.
REQ-015 SHALL read addr0 as intline[7:0], addr1 as {7'b0, intline[8]}, addr2/addr3 as stored, and rsvd bits as 0.
REQ-016 SHALL make a config write visible from the next cycle; a compare in the write cycle uses old values.
REQ-017 SHALL keep vcnt (9 bit): 0 on frame_start, else +1 on line_start, saturating at 511; line_num = vcnt.
REQ-018 SHALL keep hcnt (8 bit): 0 on line_start or frame_start, else +1 on hcnt_tick, saturating at 255.
REQ-019 SHALL define match = hcnt_tick && !line_start && !frame_start && hcnt == inthpos, using the pre-increment hcnt.
REQ-020 SHALL pulse int_start_frm one cycle after match when frm_en && vcnt == intline && !frm_fired.
REQ-021 SHALL keep phase (4 bit): 0 on frame_start; on line_start it wraps to 0 if phase == step, else +1.
REQ-022 SHALL pulse int_start_lin one cycle after match when lin_en && phase == 0 && !lin_fired, i.e. every step+1 lines.
REQ-023 SHALL set frm_fired/lin_fired when the respective strobe is issued and clear both on line_start/frame_start, giving at most one strobe per line each, including the inthpos = 255 saturation case.
REQ-024 SHALL allow both strobes in the same cycle when both conditions hold.
REQ-025 SHALL give frame_start priority over line_start when both occur in one cycle.
REQ-026 SHALL NOT issue a strobe when the line or frame boundary lands on the matching tick, per REQ-019.
REQ-027 SHALL suppress any strobe not yet issued when frm_en or lin_en is cleared; re-enabling mid-line SHALL allow the strobe if match occurs later in that line.
REQ-028 SHALL NOT issue a frame strobe on a saturated vcnt = 511 with intline = 511 more than once per line.

Reset
REQ-029 SHALL reset, while res is high: intline = 0, shadow_lo = 0, inthpos = 0, INTCFG = 8'h01, vcnt = 0, hcnt = 0, phase = 0, fired flags = 0, int_start_frm = 0, int_start_lin = 0.
REQ-030 SHALL, on reset mid-line, drop any pending strobe and issue none until a match after res deasserts.

Structure
REQ-031 SHALL place register addresses, INTCFG bit positions and reset values in shared package int_sched_pkg.
REQ-032 SHALL implement the vcnt/hcnt/phase counters in one sub-module, int_sched_raster; registers and strobe logic stay in int_sched.

Verification
REQ-033 SHALL cover: reset, INTCFG=01, intline=0, inthpos=0 -> int_start_frm pulse 1 cycle after first hcnt_tick of line 0; readback addr3 = 8'h01.
REQ-034 SHALL cover: write addr0=0x2C, then addr1=0x01 -> intline=300 only after the addr1 write; frame strobe on line 300, hpos match; none on line 44.
REQ-035 SHALL cover: INTCFG=8'h22 (step=2, lin_en) -> line strobes on lines 0,3,6,...; frame_start mid-sequence restarts at phase 0.
REQ-036 SHALL cover: inthpos=255, 300 ticks in one line -> exactly one int_start_lin.
REQ-037 SHALL cover: frame_start and line_start together -> vcnt=0, hcnt=0, phase=0; a tick coincident with line_start at inthpos=0 gives no strobe.
REQ-038 SHALL cover: res asserted asynchronously between match and strobe -> no strobe, all outputs 0 immediately.
